// File: rtl/dpm_pkg.sv
// Shared DPM datapath definitions: operand size codes, default widths and
// the sized-field msb lookup.
package dpm_pkg;

   localparam int QW_DEF = 32;
   localparam int CW_DEF = 5;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_WORD = 2'b01,
      SIZE_LONG = 2'b10
   } size_e;

   // Encoding 2'b11 is treated as longword as well.
   function automatic logic [7:0] size_msb(input logic [1:0] size);
      logic [7:0] msb;
      case (size)
         SIZE_BYTE: msb = 8'd7;
         SIZE_WORD: msb = 8'd15;
         default:   msb = 8'd31;
      endcase
      return msb;
   endfunction

endpackage

// File: rtl/dpm_qreg_if.sv
// Command/data bundle between the DPM microcode sequencer (master) and the
// Q register block (slave).
interface dpm_qreg_if
   import dpm_pkg::*;
   #(
      parameter int QW = QW_DEF,
      parameter int CW = CW_DEF
   );

   logic          dq_q_load_h;
   logic          dq_q_shl_h;
   logic          dq_q_shr_h;
   logic [1:0]    size_h;
   logic          q_sin_h;
   logic [QW-1:0] wbus_in_h;
   logic          loop_load_h;
   logic [CW-1:0] loop_cnt_in_h;
   logic [QW-1:0] q_h;
   logic          q_sout_shl_h;
   logic          q_sout_shr_h;
   logic          q_zero_h;
   logic          loopf_h;

   modport master (
      output dq_q_load_h, dq_q_shl_h, dq_q_shr_h, size_h, q_sin_h,
             wbus_in_h, loop_load_h, loop_cnt_in_h,
      input  q_h, q_sout_shl_h, q_sout_shr_h, q_zero_h, loopf_h
   );

   modport slave (
      input  dq_q_load_h, dq_q_shl_h, dq_q_shr_h, size_h, q_sin_h,
             wbus_in_h, loop_load_h, loop_cnt_in_h,
      output q_h, q_sout_shl_h, q_sout_shr_h, q_zero_h, loopf_h
   );

endinterface

// File: rtl/dpm_qreg_stepcnt.sv
// Multiply/divide step counter: loadable, decrements on each accepted shift,
// saturates at zero and flags a nonzero count.
module dpm_qreg_stepcnt #(
   parameter int CW = 5
) (
   input  logic          clk_h,
   input  logic          reset_l,
   input  logic          load,
   input  logic [CW-1:0] cnt_in,
   input  logic          dec,
   output logic          loopf
);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (load) begin
         cnt_next = cnt_in;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk_h or negedge reset_l) begin
      if (!reset_l) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign loopf = (cnt_reg != '0);

endmodule

// File: rtl/dpm_qreg.sv
// DPM Q register: sized load/shift datapath with shift-out and zero flags,
// plus the step counter that drives the iteration loop flag.
module dpm_qreg
   import dpm_pkg::*;
   #(
      parameter int QW = QW_DEF,
      parameter int CW = CW_DEF
   ) (
      input  logic     clk_h,
      input  logic     reset_l,
      dpm_qreg_if.slave qbus
   );

   localparam int IW = $clog2(QW);

   logic [IW-1:0] msb_idx;
   logic [QW-1:0] is_msb;
   logic [QW-1:0] in_field;
   logic [QW-1:0] shl_val;
   logic [QW-1:0] shr_val;
   logic [QW-1:0] q_reg;
   logic [QW-1:0] q_next;
   logic          shift_ok;

   assign msb_idx = IW'(size_msb(qbus.size_h));

   // Per-bit field membership and shifted values; bits above the sized
   // field simply keep their current value.
   for (genvar gi = 0; gi < QW; gi++) begin : g_bit
      assign is_msb[gi]   = (msb_idx == IW'(gi));
      assign in_field[gi] = (IW'(gi) <= msb_idx);

      if (gi == 0) begin : g_lsb
         assign shl_val[gi] = qbus.q_sin_h;
      end else begin : g_nlsb
         assign shl_val[gi] = in_field[gi] ? q_reg[gi-1] : q_reg[gi];
      end

      if (gi == QW - 1) begin : g_top
         assign shr_val[gi] = is_msb[gi] ? qbus.q_sin_h : q_reg[gi];
      end else begin : g_ntop
         assign shr_val[gi] = is_msb[gi]   ? qbus.q_sin_h :
                              in_field[gi] ? q_reg[gi+1]  : q_reg[gi];
      end
   end

   // shl and shr together is an illegal encoding and is ignored.
   assign shift_ok = !qbus.dq_q_load_h && (qbus.dq_q_shl_h ^ qbus.dq_q_shr_h);

   always_comb begin
      q_next = q_reg;
      if (qbus.dq_q_load_h) begin
         q_next = qbus.wbus_in_h;
      end else if (shift_ok && qbus.dq_q_shl_h) begin
         q_next = shl_val;
      end else if (shift_ok && qbus.dq_q_shr_h) begin
         q_next = shr_val;
      end
   end

   always_ff @(posedge clk_h or negedge reset_l) begin
      if (!reset_l) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   // Shift-out and zero flags depend only on registered Q and size, so the
   // shift-in mux never sees a combinational path back to its own input.
   assign qbus.q_h          = q_reg;
   assign qbus.q_sout_shl_h = |(q_reg & is_msb);
   assign qbus.q_sout_shr_h = q_reg[0];
   assign qbus.q_zero_h     = ~|(q_reg & in_field);

   dpm_qreg_stepcnt #(
      .CW(CW)
   ) u_stepcnt (
      .clk_h   (clk_h),
      .reset_l (reset_l),
      .load    (qbus.loop_load_h),
      .cnt_in  (qbus.loop_cnt_in_h),
      .dec     (shift_ok),
      .loopf   (qbus.loopf_h)
   );

endmodule

// File: tb/tb_dpm_qreg.sv
// Directed-vector bench for dpm_qreg: table of commands with hand-computed
// results, plus short sequences for async reset and combinational size change.
module tb_dpm_qreg;

   logic clk_h;
   logic reset_l;
   int   tests;
   int   fails;

   dpm_qreg_if bus ();

   dpm_qreg dut (
      .clk_h   (clk_h),
      .reset_l (reset_l),
      .qbus    (bus)
   );

   initial clk_h = 1'b0;
   always #5 clk_h = ~clk_h;

   typedef struct {
      logic        ld;
      logic        shl;
      logic        shr;
      logic [1:0]  size;
      logic        sin;
      logic [31:0] wbus;
      logic        lld;
      logic [4:0]  lcnt;
      logic [31:0] eq;
      logic        esl;
      logic        esr;
      logic        ez;
      logic        ef;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic ld, input logic shl, input logic shr,
                               input logic [1:0] size, input logic sin,
                               input logic [31:0] wbus, input logic lld,
                               input logic [4:0] lcnt, input logic [31:0] eq,
                               input logic esl, input logic esr, input logic ez,
                               input logic ef);
      vec_t v;
      v.ld = ld; v.shl = shl; v.shr = shr; v.size = size; v.sin = sin;
      v.wbus = wbus; v.lld = lld; v.lcnt = lcnt; v.eq = eq;
      v.esl = esl; v.esr = esr; v.ez = ez; v.ef = ef;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] eq, input logic esl,
                          input logic esr, input logic ez, input logic ef);
      chk({tag, " q"},     bus.q_h, eq);
      chk({tag, " sshl"},  {31'd0, bus.q_sout_shl_h}, {31'd0, esl});
      chk({tag, " sshr"},  {31'd0, bus.q_sout_shr_h}, {31'd0, esr});
      chk({tag, " zero"},  {31'd0, bus.q_zero_h}, {31'd0, ez});
      chk({tag, " loopf"}, {31'd0, bus.loopf_h}, {31'd0, ef});
   endtask

   task automatic idle_inputs();
      bus.dq_q_load_h   = 1'b0;
      bus.dq_q_shl_h    = 1'b0;
      bus.dq_q_shr_h    = 1'b0;
      bus.q_sin_h       = 1'b0;
      bus.loop_load_h   = 1'b0;
      bus.loop_cnt_in_h = 5'd0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset_l = 1'b0;
      idle_inputs();
      bus.size_h    = 2'b10;
      bus.wbus_in_h = 32'h0;

      //   ld shl shr size  sin wbus          lld cnt   q             sl sr z  f
      add(1, 0, 0, 2'b10, 0, 32'h80000001, 0, 5'd0, 32'h80000001, 1, 1, 0, 0);
      add(0, 1, 0, 2'b10, 1, 32'h0,        0, 5'd0, 32'h00000003, 0, 1, 0, 0);
      add(1, 0, 0, 2'b00, 0, 32'h12345681, 0, 5'd0, 32'h12345681, 1, 1, 0, 0);
      add(0, 0, 1, 2'b00, 1, 32'h0,        0, 5'd0, 32'h123456C0, 1, 0, 0, 0);
      add(1, 1, 0, 2'b10, 0, 32'hAAAA0000, 0, 5'd0, 32'hAAAA0000, 1, 0, 0, 0);
      add(0, 1, 1, 2'b10, 1, 32'h0,        0, 5'd0, 32'hAAAA0000, 1, 0, 0, 0);
      add(0, 0, 0, 2'b10, 0, 32'h0,        1, 5'd3, 32'hAAAA0000, 1, 0, 0, 1);
      add(0, 0, 1, 2'b10, 0, 32'h0,        0, 5'd0, 32'h55550000, 0, 0, 0, 1);
      add(0, 0, 1, 2'b10, 0, 32'h0,        0, 5'd0, 32'h2AAA8000, 0, 0, 0, 1);
      add(0, 0, 1, 2'b10, 0, 32'h0,        0, 5'd0, 32'h15554000, 0, 0, 0, 0);
      add(0, 0, 1, 2'b10, 0, 32'h0,        0, 5'd0, 32'h0AAAA000, 0, 0, 0, 0);
      add(0, 1, 0, 2'b10, 0, 32'h0,        1, 5'd2, 32'h15554000, 0, 0, 0, 1);
      add(0, 1, 0, 2'b10, 0, 32'h0,        0, 5'd0, 32'h2AAA8000, 0, 0, 0, 1);
      add(0, 1, 0, 2'b10, 0, 32'h0,        0, 5'd0, 32'h55550000, 0, 0, 0, 0);
      add(1, 0, 0, 2'b01, 0, 32'hFFFF0000, 0, 5'd0, 32'hFFFF0000, 0, 0, 1, 0);

      // Reset state, before any clock edge
      #2;
      chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk_h);
      @(posedge clk_h);
      #1 reset_l = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         bus.dq_q_load_h   = vq[i].ld;
         bus.dq_q_shl_h    = vq[i].shl;
         bus.dq_q_shr_h    = vq[i].shr;
         bus.size_h        = vq[i].size;
         bus.q_sin_h       = vq[i].sin;
         bus.wbus_in_h     = vq[i].wbus;
         bus.loop_load_h   = vq[i].lld;
         bus.loop_cnt_in_h = vq[i].lcnt;
         @(posedge clk_h);
         #1;
         chk_all($sformatf("v%0d", i), vq[i].eq, vq[i].esl, vq[i].esr, vq[i].ez, vq[i].ef);
      end

      // Size change acts combinationally on zero and sout flags
      idle_inputs();
      bus.size_h = 2'b10;
      #1;
      chk_all("size_long", 32'hFFFF0000, 1'b1, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-loop with a pending shift
      bus.dq_q_load_h   = 1'b1;
      bus.wbus_in_h     = 32'hDEADBEEF;
      bus.loop_load_h   = 1'b1;
      bus.loop_cnt_in_h = 5'd7;
      @(posedge clk_h);
      #1;
      chk_all("preload", 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1);
      idle_inputs();
      bus.dq_q_shl_h = 1'b1;
      bus.q_sin_h    = 1'b1;
      #2 reset_l = 1'b0;
      #1;
      chk_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk_h);
      #1;
      chk_all("rst_hold", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      reset_l = 1'b1;
      idle_inputs();
      @(posedge clk_h);
      #1;
      chk_all("post_rst", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
